axis_block_detector: RTL and testbench
======================================

# axis_block_detector

Per-port AXI-Stream stall detector for the co-simulation deadlock infrastructure. Watches the TVALID/TREADY pair of each stream port on a DUT instance and raises a registered per-port block flag once that port has been stalled for a programmable number of consecutive cycles. Its `axis_block_sigs` output feeds the deadlock monitors, which consume these flags. It is the producing end of that signal.

## Interface
Parameters:
- `N_PORTS`, 3: number of monitored stream ports.
- `STALL_CYCLES`, 16: consecutive stall cycles before block asserts; legal range is 1 to 2^16-1.
- `CONSUMER_MASK`, 3'b110: bit i = 1 means the DUT consumes on port i; bit i = 0 means the DUT produces on port i.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `clear`, in, 1: synchronous clear of all trackers.
- `port_en`, in, N_PORTS: per-port enable. A disabled port is held in IDLE.
- `axis_tvalid`, in, N_PORTS: observed TVALID per port.
- `axis_tready`, in, N_PORTS: observed TREADY per port.
- `axis_block_sigs`, out, N_PORTS: per-port registered block flag.
- `any_block`, out, 1: registered OR of all `axis_block_sigs`.
- `block_events`, out, N_PORTS*8: only present under the macro in Configuration. Per-port count of block-assertion events.

## Operation
- Stall condition for port i:
  - Consumer port: `tready && !tvalid`.
  - Producer port: `tvalid && !tready`.
  - The condition is gated by `port_en[i]`.
- A transfer (`tvalid && tready`) is never a stall.
- Each port runs a three-state FSM: IDLE, STALL, BLOCKED.
  - IDLE to STALL: stall is seen; the counter loads 1.
  - STALL, stall persists: counter increments. When the counter equals `STALL_CYCLES`, go to BLOCKED.
  - STALL to IDLE: stall drops; counter clears.
  - BLOCKED: held while stall persists. Go to IDLE when stall drops.
- Counter rules:
  - Width is `$clog2(STALL_CYCLES+1)`.
  - The counter saturates at `STALL_CYCLES` and never wraps.
- Special case `STALL_CYCLES == 1`: IDLE goes directly to BLOCKED on the first stall cycle.
- `axis_block_sigs[i]` is 1 exactly when port i's state is BLOCKED.
- `clear` forces every port to IDLE and zeroes its counter. `clear` has priority over all transitions.
- Deasserting `port_en[i]` acts as a per-port clear.
- Reset value: every output is 0, every FSM is in IDLE, every counter is 0.

## Timing
- Block assertion: stall held on edges 1..S, where S = `STALL_CYCLES`. `axis_block_sigs[i]` is 1 after edge S. It is visible in the cycle that follows the S-th stall cycle.
- Block release: one cycle. Stall low on edge k means the flag is 0 after edge k.
- Gap handling: any single non-stall cycle restarts the count from zero. Gaps do not accumulate.
- `any_block` lags `axis_block_sigs` by one cycle.
- `reset` asserted mid-stall clears all outputs immediately, with no clock needed. Counting restarts from 0 after reset is released.
- `clear` and a stall in the same cycle: `clear` wins. Counting restarts on the next stall cycle.
- Ports are fully independent. Simultaneous assertion on several ports is legal.

## Configuration
- Macro: `AXIS_BLOCK_STATS_EN`.
- Defined:
  - `block_events` exists.
  - Each port has an 8-bit counter that increments on every BLOCKED entry and saturates at 255.
  - The counter clears on `reset` or `clear`, but not on `port_en` low.
- Undefined:
  - The port and the counters are absent.
  - All other behaviour is identical.

## Structure
- Package `axis_block_pkg` holds:
  - The state typedef `stall_state_t` (IDLE, STALL, BLOCKED).
  - The `EVT_W` = 8 constant.
  - The `stall_cond(tvalid, tready, is_consumer)` function.
- Sub-module `axis_stall_tracker`:
  - Contains one FSM, one counter and the optional event counter.
  - Instantiated `N_PORTS` times by a generate loop.
- The top level holds only the generate loop and the `any_block` register.

## Test plan
All scenarios use `STALL_CYCLES`=4 and `CONSUMER_MASK`=3'b110.
1. Producer stall: port0 with tvalid=1, tready=0 for 6 cycles. Block[0] rises after the 4th edge and stays 1 through cycle 6. It drops one cycle after tready=1. `any_block` follows one cycle later.
2. Gap restart: port1 with tready=1, tvalid=0 for 3 cycles, 1 transfer cycle, then 3 more stall cycles. Block[1] never asserts.
3. Transfers: port2 with tvalid=tready=1 for 20 cycles. All flags stay 0 and the FSM stays IDLE.
4. Clear and reset: `clear` asserted on the 3rd stall cycle; block first asserts 4 stall cycles after `clear` drops. `reset` pulsed while blocked; flags go to 0 asynchronously, before the next clock edge.
5. Simultaneous and disabled ports: all three ports stalled together give block=3'b111 on the same cycle. With `port_en[1]`=0, block=3'b101.
6. Statistics (`AXIS_BLOCK_STATS_EN` defined): 300 block episodes on port0 give `block_events[7:0]`=255 (saturated). `clear` returns it to 0.

Source files
------------

// File: rtl/axis_block_pkg.sv
// axis_block_pkg
//   Shared types and helpers for the AXI-Stream block detector.
//   stall_state_t : per-port tracker state (IDLE, STALL, BLOCKED)
//   EVT_W         : width of the optional per-port block-event counter
//   stall_cond()  : stall rule for one port given its direction
package axis_block_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    BLOCKED
  } stall_state_t;

  localparam int unsigned EVT_W = 8;

  // A consumer stalls when it is ready but nothing arrives; a producer
  // stalls when it offers data that is not taken. A transfer is never a stall.
  function automatic logic stall_cond(input logic tvalid,
                                      input logic tready,
                                      input logic is_consumer);
    return is_consumer ? (tready && !tvalid) : (tvalid && !tready);
  endfunction

endpackage

// File: rtl/axis_block_detector_tracker.sv
// axis_stall_tracker
//   Single-port stall tracker: FSM plus saturating stall counter. The
//   block flag is the registered BLOCKED state.
//   Optional macro AXIS_BLOCK_STATS_EN adds an 8-bit saturating count of
//   BLOCKED entries (cleared by reset/clear, not by port_en low).
// Ports:
//   clock, reset (async, active-high), clear (sync)
//   port_en        : low holds the tracker in IDLE with a zero counter
//   tvalid, tready : observed handshake of this port
//   block          : 1 while the tracker is BLOCKED
//   block_events   : (AXIS_BLOCK_STATS_EN only) BLOCKED entry count
module axis_stall_tracker
  import axis_block_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 16,
  parameter logic        IS_CONSUMER  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             port_en,
  input  logic             tvalid,
  input  logic             tready,
`ifdef AXIS_BLOCK_STATS_EN
  output logic [EVT_W-1:0] block_events,
`endif
  output logic             block
);

  localparam int unsigned      CNT_W   = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  stall_state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             stall;
  logic             flush;

  assign stall = port_en && stall_cond(tvalid, tready, IS_CONSUMER);
  assign flush = clear || !port_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (stall) begin
            cnt_nxt   = CNT_ONE;
            state_nxt = (CNT_MAX == CNT_ONE) ? BLOCKED : STALL;
          end
        end
        STALL: begin
          if (stall) begin
            // In STALL the count is always below the threshold, so the
            // increment cannot overflow.
            cnt_nxt = cnt + CNT_ONE;
            if (cnt + CNT_ONE == CNT_MAX) state_nxt = BLOCKED;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        BLOCKED: begin
          if (!stall) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    block = (state == BLOCKED);
  end

`ifdef AXIS_BLOCK_STATS_EN
  logic enter_blocked;
  assign enter_blocked = (state_nxt == BLOCKED) && (state != BLOCKED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      block_events <= '0;
    end else if (clear) begin
      block_events <= '0;
    end else if (enter_blocked && (block_events != '1)) begin
      block_events <= block_events + EVT_W'(1);
    end
  end
`endif

endmodule

// File: rtl/axis_block_detector.sv
// axis_block_detector
//   Per-port AXI-Stream stall detector. Raises a registered block flag per
//   port after STALL_CYCLES consecutive stall cycles, plus a registered OR.
//   Optional macro AXIS_BLOCK_STATS_EN exposes per-port block-event counts.
// Parameters: N_PORTS, STALL_CYCLES (1..65535), CONSUMER_MASK (1 = consumer)
// Ports:
//   clock, reset (async, active-high), clear (sync, all ports)
//   port_en, axis_tvalid, axis_tready : per-port enable and handshake
//   axis_block_sigs : per-port block flags
//   any_block       : OR of axis_block_sigs, one cycle later
//   block_events    : (AXIS_BLOCK_STATS_EN only) N_PORTS x 8-bit counts
module axis_block_detector
  import axis_block_pkg::*;
#(
  parameter int unsigned          N_PORTS       = 3,
  parameter int unsigned          STALL_CYCLES  = 16,
  parameter logic [N_PORTS-1:0]   CONSUMER_MASK = 3'b110
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [N_PORTS-1:0]         port_en,
  input  logic [N_PORTS-1:0]         axis_tvalid,
  input  logic [N_PORTS-1:0]         axis_tready,
`ifdef AXIS_BLOCK_STATS_EN
  output logic [N_PORTS*EVT_W-1:0]   block_events,
`endif
  output logic [N_PORTS-1:0]         axis_block_sigs,
  output logic                       any_block
);

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    axis_stall_tracker #(
      .STALL_CYCLES (STALL_CYCLES),
      .IS_CONSUMER  (CONSUMER_MASK[i])
    ) u_tracker (
      .clock        (clock),
      .reset        (reset),
      .clear        (clear),
      .port_en      (port_en[i]),
      .tvalid       (axis_tvalid[i]),
      .tready       (axis_tready[i]),
`ifdef AXIS_BLOCK_STATS_EN
      .block_events (block_events[i*EVT_W +: EVT_W]),
`endif
      .block        (axis_block_sigs[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) any_block <= 1'b0;
    else       any_block <= |axis_block_sigs;
  end

endmodule

// File: tb/tb_axis_block_detector.sv
// tb_axis_block_detector
//   Directed scenarios plus randomized handshakes, checked against a model
//   that tracks the length of each port's current stall run.
//   With AXIS_BLOCK_STATS_EN defined the block_events counts are checked too.
module tb_axis_block_detector;

  localparam int unsigned N = 3;
  localparam int unsigned S = 4;
  localparam logic [2:0]  MASK = 3'b110;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic [N-1:0] port_en = '0;
  logic [N-1:0] axis_tvalid = '0;
  logic [N-1:0] axis_tready = '0;
  logic [N-1:0] axis_block_sigs;
  logic         any_block;
`ifdef AXIS_BLOCK_STATS_EN
  logic [N*8-1:0] block_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: length of the current stall run per port, expected flags.
  int         run [N];
  int         evt [N];
  logic [N-1:0] exp_block = '0;
  logic         exp_any   = 1'b0;

  axis_block_detector #(
    .N_PORTS       (N),
    .STALL_CYCLES  (S),
    .CONSUMER_MASK (MASK)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .clear           (clear),
    .port_en         (port_en),
    .axis_tvalid     (axis_tvalid),
    .axis_tready     (axis_tready),
`ifdef AXIS_BLOCK_STATS_EN
    .block_events    (block_events),
`endif
    .axis_block_sigs (axis_block_sigs),
    .any_block       (any_block)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      run[p] = 0;
      evt[p] = 0;
    end
    exp_block = '0;
    exp_any   = 1'b0;
  endtask

  // Drive one cycle, advance the model across the edge, compare after it.
  task automatic step(input logic clr, input logic [N-1:0] en,
                      input logic [N-1:0] tv, input logic [N-1:0] tr);
    logic new_any;
    logic st;
    clear = clr; port_en = en; axis_tvalid = tv; axis_tready = tr;
    @(posedge clock);
    new_any = |exp_block;
    if (clr) for (int p = 0; p < N; p++) evt[p] = 0;
    for (int p = 0; p < N; p++) begin
      st = en[p] && (MASK[p] ? (tr[p] && !tv[p]) : (tv[p] && !tr[p]));
      if (clr || !en[p] || !st) run[p] = 0;
      else                      run[p] = run[p] + 1;
      if (run[p] == S && evt[p] < 255) evt[p] = evt[p] + 1;
      exp_block[p] = (run[p] >= S);
    end
    exp_any = new_any;
    #1;
    check("block_sigs", 32'(axis_block_sigs), 32'(exp_block));
    check("any_block", 32'(any_block), 32'(exp_any));
`ifdef AXIS_BLOCK_STATS_EN
    for (int p = 0; p < N; p++)
      check("block_events", 32'(block_events[p*8 +: 8]), 32'(evt[p]));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("async_rst_block", 32'(axis_block_sigs), 32'd0);
    check("async_rst_any", 32'(any_block), 32'd0);
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] tv, tr, en;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_block", 32'(axis_block_sigs), 32'd0);
    check("reset_any", 32'(any_block), 32'd0);
`ifdef AXIS_BLOCK_STATS_EN
    check("reset_events", 32'(block_events), 32'd0);
`endif
    reset = 1'b0;

    // 1. producer stall on port0 for 6 cycles, then a transfer
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 3'b111, 3'b001, 3'b000);
      check("s1_block0", 32'(axis_block_sigs[0]), (i >= 4) ? 32'd1 : 32'd0);
    end
    step(1'b0, 3'b111, 3'b001, 3'b001);
    check("s1_release", 32'(axis_block_sigs[0]), 32'd0);
    check("s1_any_lag", 32'(any_block), 32'd1);
    step(1'b0, 3'b111, 3'b000, 3'b000);
    check("s1_any_drop", 32'(any_block), 32'd0);

    // 2. consumer port1: 3 stalls, one transfer, 3 stalls
    repeat (3) step(1'b0, 3'b111, 3'b000, 3'b010);
    step(1'b0, 3'b111, 3'b010, 3'b010);
    repeat (3) begin
      step(1'b0, 3'b111, 3'b000, 3'b010);
      check("s2_no_block", 32'(axis_block_sigs[1]), 32'd0);
    end
    step(1'b0, 3'b111, 3'b000, 3'b000);

    // 3. continuous transfers on port2
    repeat (20) begin
      step(1'b0, 3'b111, 3'b100, 3'b100);
      check("s3_idle", 32'(axis_block_sigs), 32'd0);
    end

    // 4. clear on the 3rd stall cycle, then a fresh count, then reset
    step(1'b0, 3'b111, 3'b001, 3'b000);
    step(1'b0, 3'b111, 3'b001, 3'b000);
    step(1'b1, 3'b111, 3'b001, 3'b000);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 3'b111, 3'b001, 3'b000);
      check("s4_after_clear", 32'(axis_block_sigs[0]), (i == 4) ? 32'd1 : 32'd0);
    end
    step(1'b0, 3'b111, 3'b001, 3'b000);
    do_reset();
    step(1'b0, 3'b111, 3'b000, 3'b000);

    // 5. all ports stall together, then port1 disabled
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 3'b111, 3'b001, 3'b110);
      check("s5_all", 32'(axis_block_sigs), (i == 4) ? 32'd7 : 32'd0);
    end
    step(1'b0, 3'b101, 3'b001, 3'b110);
    check("s5_disabled", 32'(axis_block_sigs), 32'd5);
    step(1'b0, 3'b111, 3'b000, 3'b000);

`ifdef AXIS_BLOCK_STATS_EN
    // 6. 300 block episodes on port0 saturate its event counter
    step(1'b1, 3'b111, 3'b000, 3'b000);
    for (int e = 0; e < 300; e++) begin
      repeat (S) step(1'b0, 3'b111, 3'b001, 3'b000);
      step(1'b0, 3'b111, 3'b000, 3'b000);
    end
    check("s6_saturated", 32'(block_events[7:0]), 32'd255);
    step(1'b1, 3'b111, 3'b000, 3'b000);
    check("s6_cleared", 32'(block_events[7:0]), 32'd0);
`endif

    // Randomized handshakes with long holds so runs reach the threshold
    tv = '0; tr = '0; en = '1;
    repeat (3000) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(7) == 0) begin
          tv[p] = 1'($urandom_range(1));
          tr[p] = 1'($urandom_range(1));
        end
        en[p] = ($urandom_range(63) != 0);
      end
      step(($urandom_range(99) == 0), en, tv, tr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
